// File: rtl/rv32i_fetch_unit.sv
// Purpose : RV32I instruction fetch; sequential word fetches over req/gnt/rvalid, {pc,instr} buffered for decode.
// Latency : req in cycle t, rvalid in t+2 (1-cycle accept, 2-cycle data) -> instr_valid_o in t+3.
// Backpres: requests stop once outstanding + buffered reaches FIFO_DEPTH; decode stalls via instr_ready_i.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   fetch_en_i                     allow new requests (in-flight responses always complete)
//   imem_req_o/gnt_i/addr_o        request channel, address held until granted
//   imem_rvalid_i/rdata_i          in-order response channel
//   redirect_i/redirect_pc_i       one-cycle restart of the fetch stream (pc low bits dropped)
//   instr_valid_o/ready_i/o/pc_o   buffer head towards decode, valid/ready handshake
//   proto_err_o                    sticky: response seen with nothing outstanding
module rv32i_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic        imem_req_o,
    input  logic        imem_gnt_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        proto_err_o
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_EXT = CW1'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX  = PW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch-side state
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard;
    logic          proto_err;

    // Instruction buffer
    fetch_entry_t  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;

    logic req_vld;
    logic req_fire;
    logic rsp_vld;
    logic rsp_push;
    logic pop;

    // Masking keeps every input bit in use while forcing word alignment.
    assign redirect_pc = redirect_pc_i & ~32'h3;

    // Credit check: a request is only issued when the buffer is guaranteed a
    // slot for its response, counting words already buffered and in flight.
    // rst_ni gates the request so it drops immediately on an async reset.
    assign req_vld = rst_ni & fetch_en_i & ~redirect_i
                   & (outstanding < MAX_OUT)
                   & (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_EXT);

    assign req_fire = req_vld & imem_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_vld  = imem_rvalid_i & (outstanding != '0);

    // Responses from the stream being abandoned (discard) and any response
    // landing in the redirect cycle never reach the buffer.
    assign rsp_push = rsp_vld & ~redirect_i & (discard == '0);

    assign pop = instr_valid_o & instr_ready_i;

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !rsp_vld) begin
            outstanding_nxt = outstanding + 1'b1;
        end else if (!req_fire && rsp_vld) begin
            outstanding_nxt = outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            outstanding <= '0;
            discard     <= '0;
            proto_err   <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_i) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                // Everything still in flight after this edge belongs to the
                // old stream; replaces any discard already pending.
                discard  <= outstanding_nxt;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_push) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (rsp_vld && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
            if (imem_rvalid_i && (outstanding == '0)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Registered (non fall-through) buffer. A flush takes priority over push
    // and pop; a pop in the flush cycle has already been taken by decode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (redirect_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (rsp_push) begin
                fifo_mem[wr_ptr] <= '{pc: resp_pc, instr: imem_rdata_i};
                wr_ptr           <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({rsp_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head          = fifo_mem[rd_ptr];
    assign imem_req_o    = req_vld;
    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (fifo_count != '0);
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign proto_err_o   = proto_err;

endmodule
